// File: rtl/mdu_pkg.sv
// Types and defaults shared by the execute-stage multicycle units
// (seq_divider, mult_controller).
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  // Per-operation result fixup flags, captured when a start is accepted
  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic dbz;
  } div_sign_t;
endpackage

// File: rtl/div_datapath.sv
// Restoring-divider datapath: operand magnitudes, remainder/quotient shift
// registers, compare-subtract, bit counter and final sign fixup.
module div_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             d_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             count_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] dvd, dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             steps_done;
  div_sign_t        sgn;

  logic             a_neg, b_neg, b_zero, q_bit;
  logic [WIDTH-1:0] a_mag, b_mag, fix_q, fix_r;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    a_neg  = d_signed & src_a[WIDTH-1];
    b_neg  = d_signed & src_b[WIDTH-1];
    a_mag  = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag  = b_neg ? (~src_b + 1'b1) : src_b;
    b_zero = (src_b == '0);
    rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_bit  = ~diff[WIDTH];
    fix_q  = sgn.dbz ? '1  : (sgn.q_neg ? (~dvd + 1'b1) : dvd);
    fix_r  = sgn.dbz ? dvd : (sgn.r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0]);
  end

  assign count_zero = steps_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      steps_done  <= 1'b0;
      sgn         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      // Divide-by-zero skips iteration but still takes the fixup cycle,
      // keeping the raw dividend in dvd so it becomes the remainder.
      dvs         <= b_mag;
      rem         <= '0;
      cnt         <= CW'(WIDTH - 1);
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= b_zero;
      if (b_zero) begin
        dvd        <= src_a;
        sgn        <= '{q_neg: 1'b0, r_neg: 1'b0, dbz: 1'b1};
        steps_done <= 1'b1;
      end else begin
        dvd        <= a_mag;
        sgn        <= '{q_neg: a_neg ^ b_neg, r_neg: a_neg, dbz: 1'b0};
        steps_done <= 1'b0;
      end
    end else if (run) begin
      if (!steps_done) begin
        rem <= q_bit ? diff : rem_sh;
        dvd <= {dvd[WIDTH-2:0], q_bit};
        if (cnt == '0) steps_done <= 1'b1;
        else           cnt        <= cnt - 1'b1;
      end else begin
        quotient  <= fix_q;
        remainder <= fix_r;
      end
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU): FSM and start/ready/done
// handshake around div_datapath.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             d_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  mdu_state_e state_q, state_d;
  logic       accept, count_zero;

  assign ready  = !reset && (state_q == IDLE || state_q == DONE);
  assign accept = start && ready;
  assign done   = (state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = RUN;
      RUN:        if (count_zero) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .run         (state_q == RUN),
    .d_signed    (d_signed),
    .src_a       (src_a),
    .src_b       (src_b),
    .count_zero  (count_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8: directed vectors plus a few
// random operations checked against native integer division.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 0, reset = 1, start = 0, d_signed = 0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         ready, done, dbz;
  logic [W-1:0] quotient, remainder;

  int errors = 0, checks = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic done_q = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .d_signed(d_signed),
    .src_a(src_a), .src_b(src_b), .ready(ready), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare against the scoreboard on each rising edge of done
  always @(negedge clk) begin
    if (!reset && done && !done_q) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: q=%0h r=%0h with empty scoreboard", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(dbz), int'(e.dbz));
      end
    end
    done_q <= done;
  end

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_before_start", int'(ready), 1);
    d_signed = sgn; src_a = a; src_b = b; start = 1;
    if (push) sb.push_back(exp_t'{eq, er, edbz});
    @(posedge clk); #1;
    start = 0;
    chk("done_drop_on_accept", int'(done), 0);
  endtask

  task automatic wait_done(input int exp_lat, input logic disturb);
    int lat = 0;
    while (lat < 40) begin
      if (disturb && lat == 3) begin
        @(negedge clk);
        start = 1; src_a = 8'h11; src_b = 8'h01; d_signed = 1;
      end
      @(posedge clk); #1;
      lat++;
      start = 0;
      if (disturb && lat == 5) src_a = 8'hEE;
      if (done) break;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                    input int lat, input logic disturb);
    issue(sgn, a, b, 1'b1, eq, er, edbz);
    wait_done(lat, disturb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic rs, md;
    #2;
    chk("reset_ready", int'(ready), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(dbz), 0);
    repeat (2) @(negedge clk);
    reset = 0; #1;
    chk("ready_after_release", int'(ready), 1);

    op(0, 8'd200, 8'd7,  8'd28,  8'd4,  0, W+1, 0);
    op(1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 0, W+1, 0);
    op(1, 8'h07,  8'hFE, 8'hFD,  8'h01, 0, W+1, 0);
    op(1, 8'h80,  8'hFF, 8'h80,  8'h00, 0, W+1, 0);
    op(0, 8'h80,  8'hFF, 8'h00,  8'h80, 0, W+1, 0);
    op(0, 8'h55,  8'h00, 8'hFF,  8'h55, 1, 1,   0);
    op(1, 8'h80,  8'h00, 8'hFF,  8'h80, 1, 1,   0);
    op(0, 8'd50,  8'd6,  8'd8,   8'd2,  0, W+1, 1);
    op(1, 8'd9,   8'd3,  8'd3,   8'd0,  0, W+1, 0);

    // Abort mid-run: no result expected from this op
    issue(0, 8'd100, 8'd3, 0, '0, '0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1; #1;
    chk("midrun_reset_ready", int'(ready), 0);
    chk("midrun_reset_done", int'(done), 0);
    chk("midrun_reset_quotient", int'(quotient), 0);
    chk("midrun_reset_remainder", int'(remainder), 0);
    @(negedge clk);
    reset = 0; #1;
    chk("midrun_release_ready", int'(ready), 1);
    op(0, 8'd100, 8'd10, 8'd10, 8'd0, 0, W+1, 0);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = (i == 5) ? '0 : W'($urandom);
      rs = 1'($urandom);
      if (rb == 0) begin
        mq = '1; mr = ra; md = 1;
      end else if (rs) begin
        mq = W'(int'($signed(ra)) / int'($signed(rb)));
        mr = W'(int'($signed(ra)) % int'($signed(rb)));
        md = 0;
      end else begin
        mq = ra / rb; mr = ra % rb; md = 0;
      end
      op(rs, ra, rb, mq, mr, md, (rb == 0) ? 1 : W+1, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
